intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl.sv | 117 +++++++++++
 tb/tb_intr_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// External interrupt controller: two-flop synchronizer, optional debounce FSM
// (enabled by defining INTR_DEBOUNCE_EN), pending latch, enable flag, lost-event counter.
module intr_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       intr_in,
   input  logic       int_en_set,
   input  logic       int_en_clr,
   input  logic       int_ack,
   output logic       intr_out,
   output logic       int_en,
   output logic       intr_pending,
   output logic [3:0] lost_cnt
);

   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_param_check
      $error("DEBOUNCE_CYCLES must lie in 2..255");
   end

   logic       s1_q, s2_q;
   logic       q_q, q_d;
   logic       event_d;
   logic       pend_q, pend_d;
   logic       en_q, en_d;
   logic [3:0] lost_q, lost_d;

`ifdef INTR_DEBOUNCE_EN
   typedef enum logic [1:0] {LOW, RISE, HIGH, FALL} db_state_e;

   localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

   db_state_e  state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= LOW;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Counter restarts from 0 on every state change and idles at 0 in LOW/HIGH.
   always_comb begin
      state_d = state_q;
      cnt_d   = 8'd0;
      case (state_q)
         LOW:  if (s2_q) state_d = RISE;
         RISE: begin
            if (!s2_q)                 state_d = LOW;
            else if (cnt_q == CNT_LAST) state_d = HIGH;
            else                        cnt_d   = cnt_q + 8'd1;
         end
         HIGH: if (!s2_q) state_d = FALL;
         FALL: begin
            if (s2_q)                   state_d = HIGH;
            else if (cnt_q == CNT_LAST) state_d = LOW;
            else                        cnt_d   = cnt_q + 8'd1;
         end
         default: state_d = LOW;
      endcase
   end

   always_comb begin
      q_q = (state_q == HIGH) || (state_q == FALL);
      q_d = (state_d == HIGH) || (state_d == FALL);
   end
`else
   assign q_d = s2_q;

   always_ff @(posedge clk) begin
      if (!reset) q_q <= 1'b0;
      else        q_q <= q_d;
   end
`endif

   // Event is detected on the edge where q rises, so pending sets together with q.
   always_comb begin
      event_d = q_d & ~q_q;
      pend_d  = event_d | (pend_q & ~int_ack);
      en_d    = en_q;
      if (int_en_set)             en_d = 1'b1;
      if (int_en_clr || int_ack)  en_d = 1'b0;
      lost_d  = lost_q;
      if (int_ack)
         lost_d = 4'd0;
      else if (event_d && pend_q && lost_q != 4'hF)
         lost_d = lost_q + 4'd1;
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         pend_q <= 1'b0;
         en_q   <= 1'b0;
         lost_q <= 4'd0;
      end else begin
         s1_q   <= intr_in;
         s2_q   <= s1_q;
         pend_q <= pend_d;
         en_q   <= en_d;
         lost_q <= lost_d;
      end
   end

   assign intr_out     = pend_q & en_q;
   assign int_en       = en_q;
   assign intr_pending = pend_q;
   assign lost_cnt     = lost_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl; follows INTR_DEBOUNCE_EN when defined.
module tb_intr_ctrl;

   localparam int DB = 8;
`ifdef INTR_DEBOUNCE_EN
   localparam int LAT  = DB + 3;
   localparam int HOLD = DB + 2;
`else
   localparam int LAT  = 3;
   localparam int HOLD = 1;
`endif

   logic       clk = 1'b0;
   logic       reset, intr_in, int_en_set, int_en_clr, int_ack;
   logic       intr_out, int_en, intr_pending;
   logic [3:0] lost_cnt;
   int         checks = 0;
   int         failures = 0;

   intr_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
      .clk(clk), .reset(reset), .intr_in(intr_in), .int_en_set(int_en_set),
      .int_en_clr(int_en_clr), .int_ack(int_ack), .intr_out(intr_out),
      .int_en(int_en), .intr_pending(intr_pending), .lost_cnt(lost_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; intr_in = 1'b0; int_en_set = 1'b0; int_en_clr = 1'b0; int_ack = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
   endtask

   task automatic fire_event();
      intr_in = 1'b1;
      repeat (HOLD) tick();
      intr_in = 1'b0;
      repeat (HOLD) tick();
   endtask

   task automatic test_reset();
      reset = 1'b0; intr_in = 1'b1; int_en_set = 1'b1; int_en_clr = 1'b0; int_ack = 1'b1;
      repeat (2) tick();
      checks++; if (intr_out !== 1'b0) begin failures++; $display("FAIL rst_intr_out actual=%0b required=0", intr_out); end
      checks++; if (int_en !== 1'b0) begin failures++; $display("FAIL rst_int_en actual=%0b required=0", int_en); end
      checks++; if (intr_pending !== 1'b0) begin failures++; $display("FAIL rst_pending actual=%0b required=0", intr_pending); end
      checks++; if (lost_cnt !== 4'd0) begin failures++; $display("FAIL rst_lost actual=%0d required=0", lost_cnt); end
      int_en_set = 1'b0; int_ack = 1'b0; reset = 1'b1;
      tick();
      checks++; if (intr_pending !== 1'b0) begin failures++; $display("FAIL rel_first_cycle actual=%0b required=0", intr_pending); end
      repeat (LAT - 2) tick();
      checks++; if (intr_pending !== 1'b0) begin failures++; $display("FAIL rel_early actual=%0b required=0", intr_pending); end
      tick();
      checks++; if (intr_pending !== 1'b1) begin failures++; $display("FAIL rel_event actual=%0b required=1", intr_pending); end
      checks++; if (intr_out !== 1'b0) begin failures++; $display("FAIL rel_out_disabled actual=%0b required=0", intr_out); end
      intr_in = 1'b0;
   endtask

   task automatic test_basic();
      do_reset();
      int_en_set = 1'b1; tick(); int_en_set = 1'b0;
      checks++; if (int_en !== 1'b1) begin failures++; $display("FAIL basic_en actual=%0b required=1", int_en); end
      intr_in = 1'b1;
      repeat (LAT - 1) tick();
      checks++; if (intr_pending !== 1'b0) begin failures++; $display("FAIL basic_early actual=%0b required=0", intr_pending); end
      tick();
      checks++; if (intr_pending !== 1'b1) begin failures++; $display("FAIL basic_pending actual=%0b required=1", intr_pending); end
      checks++; if (intr_out !== 1'b1) begin failures++; $display("FAIL basic_out actual=%0b required=1", intr_out); end
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      checks++; if (intr_pending !== 1'b0) begin failures++; $display("FAIL ack_pending actual=%0b required=0", intr_pending); end
      checks++; if (intr_out !== 1'b0) begin failures++; $display("FAIL ack_out actual=%0b required=0", intr_out); end
      checks++; if (int_en !== 1'b0) begin failures++; $display("FAIL ack_en actual=%0b required=0", int_en); end
      repeat (6) tick();
      checks++; if (intr_pending !== 1'b0) begin failures++; $display("FAIL held_level_one_event actual=%0b required=0", intr_pending); end
      intr_in = 1'b0; repeat (LAT) tick();
      intr_in = 1'b1; repeat (LAT) tick();
      checks++; if (intr_pending !== 1'b1) begin failures++; $display("FAIL rearm_event actual=%0b required=1", intr_pending); end
      checks++; if (intr_out !== 1'b0) begin failures++; $display("FAIL rearm_out actual=%0b required=0", intr_out); end
      intr_in = 1'b0;
   endtask

   task automatic test_enable();
      do_reset();
      intr_in = 1'b1; repeat (LAT) tick(); intr_in = 1'b0;
      checks++; if (intr_pending !== 1'b1) begin failures++; $display("FAIL en_pending actual=%0b required=1", intr_pending); end
      checks++; if (intr_out !== 1'b0) begin failures++; $display("FAIL en_out_off actual=%0b required=0", intr_out); end
      int_en_set = 1'b1; tick(); int_en_set = 1'b0;
      checks++; if (intr_out !== 1'b1) begin failures++; $display("FAIL en_out_on actual=%0b required=1", intr_out); end
      int_en_set = 1'b1; int_en_clr = 1'b1; tick(); int_en_set = 1'b0; int_en_clr = 1'b0;
      checks++; if (int_en !== 1'b0) begin failures++; $display("FAIL en_clr_wins actual=%0b required=0", int_en); end
      checks++; if (intr_out !== 1'b0) begin failures++; $display("FAIL en_clr_out actual=%0b required=0", intr_out); end
      checks++; if (intr_pending !== 1'b1) begin failures++; $display("FAIL en_pending_kept actual=%0b required=1", intr_pending); end
      int_en_set = 1'b1; int_ack = 1'b1; tick(); int_en_set = 1'b0; int_ack = 1'b0;
      checks++; if (int_en !== 1'b0) begin failures++; $display("FAIL en_ack_wins actual=%0b required=0", int_en); end
      checks++; if (intr_pending !== 1'b0) begin failures++; $display("FAIL en_ack_clears actual=%0b required=0", intr_pending); end
      int_en_set = 1'b1; tick(); int_en_set = 1'b0;
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      checks++; if (int_en !== 1'b0) begin failures++; $display("FAIL idle_ack_en actual=%0b required=0", int_en); end
      checks++; if (lost_cnt !== 4'd0) begin failures++; $display("FAIL idle_ack_lost actual=%0d required=0", lost_cnt); end
   endtask

   task automatic test_lost();
      do_reset();
      repeat (4) fire_event();
      repeat (LAT + 1) tick();
      checks++; if (lost_cnt !== 4'd3) begin failures++; $display("FAIL lost_three actual=%0d required=3", lost_cnt); end
      checks++; if (intr_pending !== 1'b1) begin failures++; $display("FAIL lost_pending actual=%0b required=1", intr_pending); end
      repeat (17) fire_event();
      repeat (LAT + 1) tick();
      checks++; if (lost_cnt !== 4'd15) begin failures++; $display("FAIL lost_saturate actual=%0d required=15", lost_cnt); end
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      checks++; if (lost_cnt !== 4'd0) begin failures++; $display("FAIL lost_ack_clear actual=%0d required=0", lost_cnt); end
      checks++; if (intr_pending !== 1'b0) begin failures++; $display("FAIL lost_ack_pending actual=%0b required=0", intr_pending); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      repeat (2) fire_event();
      repeat (LAT) tick();
      checks++; if (lost_cnt !== 4'd1) begin failures++; $display("FAIL b2b_lost_setup actual=%0d required=1", lost_cnt); end
      intr_in = 1'b1;
      repeat (LAT - 1) tick();
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      checks++; if (intr_pending !== 1'b1) begin failures++; $display("FAIL b2b_pending_kept actual=%0b required=1", intr_pending); end
      checks++; if (lost_cnt !== 4'd0) begin failures++; $display("FAIL b2b_lost_zero actual=%0d required=0", lost_cnt); end
      checks++; if (int_en !== 1'b0) begin failures++; $display("FAIL b2b_en actual=%0b required=0", int_en); end
      int_en_set = 1'b1; tick(); int_en_set = 1'b0;
      checks++; if (intr_out !== 1'b1) begin failures++; $display("FAIL b2b_out actual=%0b required=1", intr_out); end
      reset = 1'b0; int_ack = 1'b1; int_en_set = 1'b1; tick();
      checks++; if ({intr_out, int_en, intr_pending, lost_cnt} !== 7'd0) begin failures++; $display("FAIL rst_priority actual=%b required=0000000", {intr_out, int_en, intr_pending, lost_cnt}); end
      int_ack = 1'b0; int_en_set = 1'b0; intr_in = 1'b0;
   endtask

`ifdef INTR_DEBOUNCE_EN
   task automatic test_debounce();
      do_reset();
      intr_in = 1'b1; repeat (5) tick(); intr_in = 1'b0;
      repeat (12) tick();
      checks++; if (intr_pending !== 1'b0) begin failures++; $display("FAIL db_glitch actual=%0b required=0", intr_pending); end
      intr_in = 1'b1; repeat (LAT) tick();
      checks++; if (intr_pending !== 1'b1) begin failures++; $display("FAIL db_event actual=%0b required=1", intr_pending); end
      repeat (12 - LAT) tick(); intr_in = 1'b0;
      repeat (20) tick();
      checks++; if (lost_cnt !== 4'd0) begin failures++; $display("FAIL db_single_event actual=%0d required=0", lost_cnt); end
      checks++; if (intr_pending !== 1'b1) begin failures++; $display("FAIL db_pending_held actual=%0b required=1", intr_pending); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_enable();
      test_lost();
      test_back_to_back();
`ifdef INTR_DEBOUNCE_EN
      test_debounce();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
